// File: rtl/arb_ram.sv
// Two-port (CPU/DMA) request/grant front end on a single-port synchronous RAM.
// Define ARB_RAM_RR_ARB_EN for round-robin arbitration; default is fixed priority A over B.
module arb_ram #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] OPEN_BUS   = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int                  IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [1:0]                 gnt;
    logic [1:0]                 port_we;
    logic                       acc_en;
    logic                       acc_we;
    logic [ADDR_WIDTH-1:0]      acc_addr;
    logic [DATA_WIDTH-1:0]      acc_wdata;
    logic                       in_range;
    logic [DATA_WIDTH-1:0]      mem [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0]      ram_q_reg;
    logic                       oob_reg;
    logic [1:0]                 rvalid_reg;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic [1:0][DATA_WIDTH-1:0] port_rdata;

`ifdef ARB_RAM_RR_ARB_EN
    // prio_b_reg set means B wins the next contention (A was granted last).
    logic prio_b_reg;

    assign gnt[0] = a_req & (~b_req | ~prio_b_reg);
    assign gnt[1] = b_req & (~a_req |  prio_b_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_reg <= 1'b0;
        end else if (gnt[0]) begin
            prio_b_reg <= 1'b1;
        end else if (gnt[1]) begin
            prio_b_reg <= 1'b0;
        end
    end
`else
    assign gnt[0] = a_req;
    assign gnt[1] = b_req & ~a_req;
`endif

    assign a_gnt   = gnt[0];
    assign b_gnt   = gnt[1];
    assign port_we = {b_we, a_we};

    // Grants are one-hot, so B's fields are selected only when B owns the bank.
    assign acc_en    = |gnt;
    assign acc_we    = gnt[1] ? b_we    : a_we;
    assign acc_addr  = gnt[1] ? b_addr  : a_addr;
    assign acc_wdata = gnt[1] ? b_wdata : a_wdata;
    assign in_range  = {1'b0, acc_addr} < DEPTH_LIM;

    // Plain BRAM template: one access per cycle, registered read port, no reset.
    always_ff @(posedge clk) begin
        if (acc_en && in_range) begin
            if (acc_we) begin
                mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
            end else begin
                ram_q_reg <= mem[acc_addr[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= '0;
            oob_reg    <= 1'b0;
        end else begin
            rvalid_reg <= gnt & ~port_we;
            if (acc_en && !acc_we) begin
                oob_reg <= ~in_range;
            end
        end
    end

    assign rd_data = oob_reg ? OPEN_BUS : ram_q_reg;

    // Each port shows fresh data during its rvalid cycle and holds it afterwards.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_WIDTH-1:0] hold_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_reg <= '0;
            end else if (rvalid_reg[gi]) begin
                hold_reg <= rd_data;
            end
        end

        assign port_rdata[gi] = rvalid_reg[gi] ? rd_data : hold_reg;
    end

    assign a_rvalid = rvalid_reg[0];
    assign b_rvalid = rvalid_reg[1];
    assign a_rdata  = port_rdata[0];
    assign b_rdata  = port_rdata[1];

endmodule

// File: tb/tb_arb_ram.sv
// Scoreboard bench for arb_ram: per-port stimulus queues, a reference memory and
// arbitration model, and a negedge monitor that checks grants, rvalid and rdata.
module tb_arb_ram;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 32'h2000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;

    arb_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit            idle;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          a_stim[$];
    txn_t          b_stim[$];
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] hold_a = '0, hold_b = '0;
    bit            a_busy = 0, b_busy = 0, a_took = 0, b_took = 0;
    bit            last_was_a = 0;
    int            a_grants = 0;
    int            tests = 0, fails = 0;
    logic [AW-1:0] pool [12] = '{16'h0010, 16'h1234, 16'h0001, 16'h0002, 16'h0005, 16'h1FFF,
                                 16'h0100, 16'h0103, 16'h0107, 16'h2000, 16'h2005, 16'hFFFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit idle, input bit we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data);
        txn_t t;
        t.idle = idle; t.we = we; t.addr = addr; t.data = data;
        return t;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
        if (int'(addr) >= DEPTH) return 8'hFF;
        return ref_mem[int'(addr)];
    endfunction

    // Commit one granted access to the reference model.
    task automatic model_access(input string port, input bit we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, output logic [DW-1:0] rexp);
        rexp = '0;
        if (we) begin
            if (int'(addr) < DEPTH) ref_mem[int'(addr)] = wdata;
            $display("[TB] %s write addr=%h data=%h", port, addr, wdata);
        end else begin
            rexp = model_read(addr);
            $display("[TB] %s read  addr=%h expect=%h", port, addr, rexp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic          ega, egb;
        logic [DW-1:0] r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_a.delete(); exp_b.delete();
                hold_a = '0; hold_b = '0;
                last_was_a = 0; a_took = 0; b_took = 0;
                continue;
            end
            check("a_rvalid", a_rvalid, exp_a.size() > 0);
            if (exp_a.size() > 0) hold_a = exp_a.pop_front();
            check("a_rdata", a_rdata, hold_a);
            check("b_rvalid", b_rvalid, exp_b.size() > 0);
            if (exp_b.size() > 0) hold_b = exp_b.pop_front();
            check("b_rdata", b_rdata, hold_b);

`ifdef ARB_RAM_RR_ARB_EN
            if (a_req && b_req) begin
                ega = !last_was_a;
                egb = last_was_a;
            end else begin
                ega = a_req;
                egb = b_req;
            end
`else
            ega = a_req;
            egb = b_req && !a_req;
`endif
            check("gnt", {a_gnt, b_gnt}, {ega, egb});
            if (ega) begin
                model_access("A", a_we, a_addr, a_wdata, r);
                if (!a_we) exp_a.push_back(r);
                last_was_a = 1;
                a_grants++;
            end else if (egb) begin
                model_access("B", b_we, b_addr, b_wdata, r);
                if (!b_we) exp_b.push_back(r);
                last_was_a = 0;
            end
            a_took = a_gnt;
            b_took = b_gnt;
        end
    end

    // Port A driver: holds a request until the monitor observed its grant.
    initial begin
        txn_t t;
        forever begin
            @(posedge clk); #1;
            if (a_busy && a_took) a_busy = 0;
            if (!a_busy) begin
                if (a_stim.size() > 0) begin
                    t = a_stim.pop_front();
                    if (t.idle) a_req = 0;
                    else begin
                        a_req = 1; a_we = t.we; a_addr = t.addr; a_wdata = t.data; a_busy = 1;
                    end
                end else a_req = 0;
            end
        end
    end

    // Port B driver
    initial begin
        txn_t t;
        forever begin
            @(posedge clk); #1;
            if (b_busy && b_took) b_busy = 0;
            if (!b_busy) begin
                if (b_stim.size() > 0) begin
                    t = b_stim.pop_front();
                    if (t.idle) b_req = 0;
                    else begin
                        b_req = 1; b_we = t.we; b_addr = t.addr; b_wdata = t.data; b_busy = 1;
                    end
                end else b_req = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 4000; i++) begin
            if (a_stim.size() == 0 && b_stim.size() == 0 && !a_busy && !b_busy) break;
            @(posedge clk); #2;
        end
        check("stim_drain", a_stim.size() + b_stim.size() + int'(a_busy) + int'(b_busy), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        int g0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        #2 rst_n = 1;

        // Write then read on A
        a_stim.push_back(mk(0, 1, 16'h0010, 8'hAB));
        a_stim.push_back(mk(0, 0, 16'h0010, 8'h00));
        wait_idle();

        // B write followed next cycle by A read of the same word
        b_stim.push_back(mk(0, 1, 16'h1234, 8'h5A));
        a_stim.push_back(mk(1, 0, 16'h0000, 8'h00));
        a_stim.push_back(mk(0, 0, 16'h1234, 8'h00));
        wait_idle();

        // Preload
        a_stim.push_back(mk(0, 1, 16'h0001, 8'h11));
        a_stim.push_back(mk(0, 1, 16'h0002, 8'h22));
        a_stim.push_back(mk(0, 1, 16'h0005, 8'h55));
        a_stim.push_back(mk(0, 1, 16'h1FFF, 8'h9C));
        for (int i = 0; i < 8; i++) a_stim.push_back(mk(0, 1, 16'h0100 + 16'(i), 8'(i)));
        wait_idle();

        // Contention: both ports read for 4 requests each
        for (int i = 0; i < 4; i++) begin
            a_stim.push_back(mk(0, 0, 16'h0001, 8'h00));
            b_stim.push_back(mk(0, 0, 16'h0002, 8'h00));
        end
        wait_idle();

        // Out-of-range write is dropped, read returns open bus, no aliasing onto 0x0005
        a_stim.push_back(mk(0, 1, 16'h2005, 8'h77));
        a_stim.push_back(mk(0, 0, 16'h2005, 8'h00));
        a_stim.push_back(mk(0, 0, 16'h0005, 8'h00));
        wait_idle();

        // 8 back-to-back reads
        for (int i = 0; i < 8; i++) a_stim.push_back(mk(0, 0, 16'h0100 + 16'(i), 8'h00));
        wait_idle();

        // Reset while a read response is pending
        g0 = a_grants;
        a_stim.push_back(mk(0, 0, 16'h0010, 8'h00));
        for (int i = 0; i < 50 && a_grants == g0; i++) begin
            @(negedge clk); #1;
        end
        check("midrst_read_granted", a_grants - g0, 1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("midrst_a_rvalid", a_rvalid, 0);
        check("midrst_a_rdata", a_rdata, 0);
        check("midrst_b_rdata", b_rdata, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        a_stim.push_back(mk(0, 0, 16'h0010, 8'h00));
        wait_idle();

        // Random traffic on both ports
        for (int i = 0; i < 300; i++) begin
            a_stim.push_back(mk($urandom_range(3) == 0, 1'($urandom_range(1)),
                                pool[$urandom_range(11)], 8'($urandom)));
            b_stim.push_back(mk($urandom_range(3) == 0, 1'($urandom_range(1)),
                                pool[$urandom_range(11)], 8'($urandom)));
        end
        wait_idle();

        check("pending_reads", exp_a.size() + exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arb_ram.md
Name: arb_ram

Overview:
- Synchronous single-bank RAM shared by two requesters:
  - Port A: CPU.
  - Port B: DMA/PPU.
- Per-port request/grant handshake with arbitration; registered read data with a valid strobe.
- Configurable width and depth; out-of-range addresses return open-bus 0xFF-style data.
- Replaces the asynchronous level-triggered memory model; synthesizable as single-port BRAM.

Parameters:
- ADDR_WIDTH, 16, address bus width of both ports.
- DATA_WIDTH, 8, data word width.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of implemented words; may be smaller than the address space.
- OPEN_BUS, all-ones of DATA_WIDTH, read value returned for addresses >= RAM_DEPTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  port A access request
- a_we  input  1  port A write (1) / read (0)
- a_addr  input  ADDR_WIDTH  port A address
- a_wdata  input  DATA_WIDTH  port A write data
- a_gnt  output  1  port A request accepted this cycle (combinational)
- a_rvalid  output  1  port A read data valid (one-cycle pulse)
- a_rdata  output  DATA_WIDTH  port A read data
- b_req  input  1  port B access request
- b_we  input  1  port B write / read
- b_addr  input  ADDR_WIDTH  port B address
- b_wdata  input  DATA_WIDTH  port B write data
- b_gnt  output  1  port B request accepted this cycle
- b_rvalid  output  1  port B read data valid
- b_rdata  output  DATA_WIDTH  port B read data

Behaviour:
- Reset (async assert, sync deassert by system):
  - a_rvalid = b_rvalid = 0.
  - a_rdata = b_rdata = 0.
  - Arbitration pointer = A.
  - RAM contents not reset.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it samples gnt=1 on a rising edge.
  - The transfer occurs on that edge.
  - At most one of a_gnt/b_gnt is high per cycle.
  - gnt is combinational from req and arbiter state only, never from rvalid.
- Single request: the requesting port is granted in the same cycle; zero wait.
- Contention (both req=1): fixed priority, A wins; B waits and may starve while A requests every cycle.
- Write: on the granted edge, mem[addr] <= wdata if addr < RAM_DEPTH; otherwise dropped silently.
- Read latency:
  - rvalid pulses exactly 1 cycle after the granted edge.
  - rdata = mem[addr] as of the granted edge, or OPEN_BUS if addr >= RAM_DEPTH.
- rdata holds its last value until the next read on that port; rvalid is only a pulse.
- Back-to-back:
  - A port may be granted every cycle; rvalid pulses every cycle for consecutive reads.
  - A write followed by a read of the same address in the next cycle (either port) returns the new data.
- Read and write on the same cycle never occur (single access), so there is no read-during-write hazard.
- A write grant produces no rvalid.
- Reset mid-operation: a pending rvalid is cancelled (stays 0); no partial write is possible since writes commit on the edge.
- Addresses compare at full ADDR_WIDTH; no wrap-around aliasing when RAM_DEPTH < 2^ADDR_WIDTH.

Optional Feature:
- Macro: ARB_RAM_RR_ARB_EN.
- Defined: round-robin arbitration.
  - On contention, grant the port opposite to the last granted port.
  - Pointer updates only on grants.
  - Single requests are still granted immediately.
- Undefined:
  - Fixed priority, A over B.
  - Pointer register absent.

Test Plan:
- Reset then A write 0xAB @0x0010, A read @0x0010 -> a_gnt both cycles; a_rvalid=1 one cycle after read grant; a_rdata=0xAB; b_rvalid stays 0.
- B write 0x5A @0x1234 cycle N, A read @0x1234 cycle N+1 -> a_rdata=0x5A at N+2.
- Both req reads every cycle for 4 cycles, A@0x0001 B@0x0002:
  - Fixed priority: a_gnt=1 x4, b_gnt=0.
  - With ARB_RAM_RR_ARB_EN: gnt alternates A,B,A,B.
- RAM_DEPTH=0x2000, A write 0x77 @0x2005 then read @0x2005 -> a_rdata=0xFF; mem[0x0005] unchanged.
- Read granted, rst_n pulsed low before the next edge -> a_rvalid=0, a_rdata=0 after reset; subsequent read works normally.
- 8 consecutive A reads @0x0100..0x0107 preloaded 0x00..0x07 -> a_rvalid high 8 consecutive cycles with data 0x00..0x07 in order.
